// File: rtl/uart_frame_parser_pkg.sv
// ---------------------------------------------------------------------------
// uart_frame_pkg
// Shared types for the UART frame parser slice.
//   frame_state_t : parser FSM states
//   frame_err_t   : 3-bit error code reported on error_code
//   DEFAULT_SOF   : default start-of-frame byte
// ---------------------------------------------------------------------------
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } frame_state_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BAD_CSUM = 3'd1,
        ERR_BAD_LEN  = 3'd2,
        ERR_TIMEOUT  = 3'd3,
        ERR_RX       = 3'd4,
        ERR_OVERRUN  = 3'd5
    } frame_err_t;

    localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/uart_frame_parser_if.sv
// ---------------------------------------------------------------------------
// uart_frame_parser_if
// Byte stream from the UART receiver plus the frame valid/ready output side.
//   message, isNew, isValid : received byte, new-byte pulse, byte qualifier
//   frame_valid/frame_ready : frame handshake
//   frame_len, payload      : presented frame (byte i at payload[8i+7:8i])
//   error, error_code       : one-cycle error pulse and sticky code
// master: byte source / frame consumer.  slave: the parser.
// ---------------------------------------------------------------------------
interface uart_frame_parser_if #(
    parameter int MAX_LEN = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [7:0]           message;
    logic                 isNew;
    logic                 isValid;
    logic                 frame_valid;
    logic                 frame_ready;
    logic [LEN_W-1:0]     frame_len;
    logic [8*MAX_LEN-1:0] payload;
    logic                 error;
    logic [2:0]           error_code;

    modport master (
        output message, isNew, isValid, frame_ready,
        input  frame_valid, frame_len, payload, error, error_code
    );

    modport slave (
        input  message, isNew, isValid, frame_ready,
        output frame_valid, frame_len, payload, error, error_code
    );

endinterface

// File: rtl/uart_frame_parser_gap_timer.sv
// ---------------------------------------------------------------------------
// gap_timer
// Inter-byte gap watchdog.
//   clock, reset : clock, synchronous active-low reset
//   clear        : a byte arrived this cycle
//   enable       : a frame is in progress
//   expired      : this is the TIMEOUT-th consecutive idle cycle
// The counter holds the number of the current idle cycle (1-based) and
// saturates at TIMEOUT.
// ---------------------------------------------------------------------------
module gap_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] FIRST = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the values from before the clock edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || !enable) begin
            // The cycle after a byte is idle cycle number 1.
            count <= FIRST;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
// Assembles receiver bytes into SOF / length / payload / checksum frames and
// presents verified frames under a valid/ready handshake.
//   clock, reset : clock, synchronous active-low reset
//   bus          : uart_frame_parser_if.slave (byte input, frame output,
//                  error pulse and code)
// Checksum is (length + sum of payload bytes) mod 256.
// ---------------------------------------------------------------------------
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN = 8,
    parameter logic [7:0] SOF     = DEFAULT_SOF,
    parameter int         TIMEOUT = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    uart_frame_parser_if.slave    bus
);
    localparam int         LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    frame_state_t          state;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      idx_q;
    logic [7:0]            sum_q;
    logic                  frame_valid_q;
    logic [8*MAX_LEN-1:0]  payload_q;
    logic                  error_q;
    frame_err_t            code_q;

    logic                  timer_on;
    logic                  gap_expired;
    frame_err_t            abort_code;

    assign timer_on = (state == LEN) || (state == PAYLOAD) || (state == CHECK);

    gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (bus.isNew),
        .enable  (timer_on),
        .expired (gap_expired)
    );

    // Reasons to abandon a frame in progress. A byte arriving in the expiry
    // cycle takes precedence over the timeout.
    // NOTE: abort_code gets a default before any branch so no latch is
    // inferred for the paths that leave it untouched.
    always_comb begin
        abort_code = ERR_NONE;
        if (timer_on) begin
            if (bus.isNew) begin
                if (!bus.isValid) begin
                    abort_code = ERR_RX;
                end else if (state == LEN &&
                             (bus.message == 8'd0 || bus.message > MAX_LEN_B)) begin
                    abort_code = ERR_BAD_LEN;
                end else if (state == CHECK && bus.message != sum_q) begin
                    abort_code = ERR_BAD_CSUM;
                end
            end else if (gap_expired) begin
                abort_code = ERR_TIMEOUT;
            end
        end
    end

    // NOTE: payload is an output register with a defined reset value, so it
    // is cleared along with the control state rather than left unreset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            sum_q         <= '0;
            frame_valid_q <= 1'b0;
            payload_q     <= '0;
            error_q       <= 1'b0;
            code_q        <= ERR_NONE;
        end else begin
            error_q <= 1'b0;
            if (abort_code != ERR_NONE) begin
                error_q <= 1'b1;
                code_q  <= abort_code;
                state   <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.isNew && bus.isValid && bus.message == SOF) begin
                            state <= LEN;
                        end
                    end
                    LEN: begin
                        if (bus.isNew) begin
                            len_q     <= bus.message[LEN_W-1:0];
                            sum_q     <= bus.message;
                            idx_q     <= '0;
                            payload_q <= '0;
                            state     <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (bus.isNew) begin
                            payload_q[8*idx_q +: 8] <= bus.message;
                            sum_q                   <= sum_q + bus.message;
                            idx_q                   <= idx_q + 1'b1;
                            if (idx_q == len_q - 1'b1) begin
                                state <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (bus.isNew) begin
                            frame_valid_q <= 1'b1;
                            state         <= DONE;
                        end
                    end
                    DONE: begin
                        // Bytes arriving while a frame is held are dropped,
                        // including in the handshake cycle.
                        if (bus.isNew) begin
                            error_q <= 1'b1;
                            code_q  <= ERR_OVERRUN;
                        end
                        if (bus.frame_ready) begin
                            frame_valid_q <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_len   = len_q;
    assign bus.payload     = payload_q;
    assign bus.error       = error_q;
    assign bus.error_code  = code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_parser
// Directed cases for each frame outcome followed by randomized frames. The
// expected result of every frame is derived from how the frame was built
// (length, data, checksum arithmetic, where it was corrupted).
// ---------------------------------------------------------------------------
module tb_uart_frame_parser;
    import uart_frame_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int TIMEOUT = 16;

    typedef logic [7:0] byte_q_t[$];

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    uart_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_frame_parser #(
        .MAX_LEN (MAX_LEN),
        .SOF     (8'hA5),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int err_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every cycle in which error is high, just after the edge.
    always @(posedge clock) begin
        #1;
        if (bus.error === 1'b1) err_log.push_back(int'(bus.error_code));
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge; returns at the next negedge with outputs updated.
    task automatic send(input logic [7:0] b, input logic v);
        bus.message = b;
        bus.isNew   = 1'b1;
        bus.isValid = v;
        @(negedge clock);
        bus.isNew   = 1'b0;
        bus.isValid = 1'b0;
    endtask

    task automatic send_seq(input byte_q_t seq, input int max_gap);
        for (int i = 0; i < seq.size(); i++) begin
            send(seq[i], 1'b1);
            if (i != seq.size() - 1) idle($urandom_range(0, max_gap));
        end
    endtask

    // Builds a well-formed frame with random data; returns the bytes and
    // the payload vector it should produce.
    task automatic make_frame(input int len, output byte_q_t seq, output logic [63:0] pl);
        logic [7:0] s;
        seq = {};
        pl  = '0;
        s   = 8'(len);
        seq.push_back(8'hA5);
        seq.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            seq.push_back(d);
            s  = s + d;
            pl = pl | (64'(d) << (8 * i));
        end
        seq.push_back(s);
    endtask

    task automatic expect_errs(input string tag, input int code);
        if (code == 0) begin
            check({tag, " error count"}, 64'(err_log.size()), 64'd0);
        end else begin
            check({tag, " error count"}, 64'(err_log.size()), 64'd1);
            if (err_log.size() > 0) check({tag, " error code"}, 64'(err_log[0]), 64'(code));
        end
        err_log.delete();
    endtask

    task automatic expect_frame_accept(input string tag, input int len, input logic [63:0] pl);
        check({tag, " frame_valid"}, 64'(bus.frame_valid), 64'd1);
        check({tag, " frame_len"}, 64'(bus.frame_len), 64'(len));
        check({tag, " payload"}, bus.payload, pl);
        idle($urandom_range(0, 3));
        check({tag, " held valid"}, 64'(bus.frame_valid), 64'd1);
        check({tag, " held payload"}, bus.payload, pl);
        bus.frame_ready = 1'b1;
        @(negedge clock);
        bus.frame_ready = 1'b0;
        check({tag, " valid drop"}, 64'(bus.frame_valid), 64'd0);
    endtask

    initial begin
        byte_q_t     seq;
        logic [63:0] pl;

        bus.message     = 8'h00;
        bus.isNew       = 1'b0;
        bus.isValid     = 1'b0;
        bus.frame_ready = 1'b0;
        reset           = 1'b0;
        idle(3);
        reset = 1'b1;
        @(negedge clock);

        check("reset frame_valid", 64'(bus.frame_valid), 64'd0);
        check("reset frame_len", 64'(bus.frame_len), 64'd0);
        check("reset payload", bus.payload, 64'd0);
        check("reset error", 64'(bus.error), 64'd0);
        check("reset error_code", 64'(bus.error_code), 64'd0);

        // Good frame held until accepted.
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 0);
        expect_errs("good", 0);
        expect_frame_accept("good", 3, 64'h332211);

        // Bad checksum, then a good one-byte frame.
        send_seq('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}, 1);
        check("bad csum no valid", 64'(bus.frame_valid), 64'd0);
        expect_errs("bad csum", 1);
        idle(2);
        check("code held", 64'(bus.error_code), 64'd1);
        send_seq('{8'hA5, 8'h01, 8'h7F, 8'h80}, 0);
        expect_errs("after csum", 0);
        expect_frame_accept("after csum", 1, 64'h7F);

        // Bad lengths and a stray byte in IDLE.
        send_seq('{8'hA5, 8'h00}, 0);
        expect_errs("len 0", 2);
        send_seq('{8'hA5, 8'h09}, 0);
        expect_errs("len 9", 2);
        send(8'h55, 1'b1);
        idle(1);
        expect_errs("stray", 0);

        // Timeout after 16 idle cycles.
        send_seq('{8'hA5, 8'h02, 8'h11}, 0);
        idle(TIMEOUT - 1);
        expect_errs("pre timeout", 0);
        idle(1);
        expect_errs("timeout", 3);
        // A byte in the expiry cycle wins.
        send_seq('{8'hA5, 8'h02, 8'h11}, 0);
        idle(TIMEOUT - 1);
        send(8'h22, 1'b1);
        send(8'h35, 1'b1);
        expect_errs("byte at expiry", 0);
        expect_frame_accept("byte at expiry", 2, 64'h2211);

        // RX error mid-frame.
        send_seq('{8'hA5, 8'h02}, 0);
        send(8'h44, 1'b0);
        expect_errs("rx err", 4);

        // Overrun in DONE, then overrun in the handshake cycle with an SOF.
        send_seq('{8'hA5, 8'h01, 8'h7F, 8'h80}, 0);
        send(8'h12, 1'b1);
        expect_errs("overrun", 5);
        check("overrun payload", bus.payload, 64'h7F);
        check("overrun len", 64'(bus.frame_len), 64'd1);
        check("overrun valid", 64'(bus.frame_valid), 64'd1);
        bus.frame_ready = 1'b1;
        send(8'hA5, 1'b1);
        bus.frame_ready = 1'b0;
        check("handshake overrun valid", 64'(bus.frame_valid), 64'd0);
        expect_errs("handshake overrun", 5);
        send_seq('{8'hA5, 8'h01, 8'h7F, 8'h80}, 0);
        expect_errs("after handshake overrun", 0);
        expect_frame_accept("after handshake overrun", 1, 64'h7F);

        // Reset mid-frame.
        send_seq('{8'hA5, 8'h03, 8'h11}, 0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("mid reset frame_len", 64'(bus.frame_len), 64'd0);
        check("mid reset payload", bus.payload, 64'd0);
        check("mid reset error_code", 64'(bus.error_code), 64'd0);
        check("mid reset valid", 64'(bus.frame_valid), 64'd0);
        expect_errs("mid reset", 0);
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 0);
        expect_errs("post reset", 0);
        expect_frame_accept("post reset", 3, 64'h332211);

        // Randomized frames.
        for (int it = 0; it < 60; it++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 5);
            len  = $urandom_range(1, MAX_LEN);
            make_frame(len, seq, pl);
            idle($urandom_range(0, 2));
            case (kind)
                0: begin
                    send_seq(seq, 3);
                    expect_errs("rnd good", 0);
                    expect_frame_accept("rnd good", len, pl);
                end
                1: begin
                    seq[seq.size() - 1] = seq[seq.size() - 1] ^ 8'($urandom_range(1, 255));
                    send_seq(seq, 3);
                    check("rnd csum no valid", 64'(bus.frame_valid), 64'd0);
                    expect_errs("rnd csum", 1);
                end
                2: begin
                    logic [7:0] bad;
                    bad = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
                    send_seq('{8'hA5, bad}, 3);
                    expect_errs("rnd len", 2);
                end
                3: begin
                    int k;
                    k = $urandom_range(1, seq.size() - 1);
                    for (int i = 0; i < k; i++) send(seq[i], 1'b1);
                    send(seq[k], 1'b0);
                    check("rnd rx no valid", 64'(bus.frame_valid), 64'd0);
                    expect_errs("rnd rx", 4);
                end
                4: begin
                    logic [7:0] b;
                    logic       v;
                    v = 1'($urandom_range(0, 1));
                    b = 8'($urandom);
                    if (v && b == 8'hA5) b = 8'h5A;
                    send(b, v);
                    idle(1);
                    check("rnd stray no valid", 64'(bus.frame_valid), 64'd0);
                    expect_errs("rnd stray", 0);
                end
                default: begin
                    send_seq(seq, 3);
                    idle($urandom_range(0, 2));
                    send(8'($urandom), 1'($urandom_range(0, 1)));
                    expect_errs("rnd overrun", 5);
                    expect_frame_accept("rnd overrun", len, pl);
                end
            endcase
        end

        idle(2);
        expect_errs("final", 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
